// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/note-off events onto a small
// pool of oscillator voices, with retrigger, free-voice and oldest-voice
// stealing priority. One event in flight at a time; strobes come out two
// cycles after the input strobe.
//
//   state | meaning
//   IDLE  | waiting for a note strobe
//   SCAN  | choosing the target voice for the latched event
//   ISSUE | output strobe cycle; voice table updated at the end of it
module voice_alloc #(
    parameter int VOICES  = 7,
    parameter int NOTE_BW = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               noteOnStrb_i,
    input  logic               noteOffStrb_i,
    input  logic [NOTE_BW-1:0] note_i,
    output logic [VOICES-1:0]  voiceSel_o,
    output logic [NOTE_BW-1:0] voiceNote_o,
    output logic               voiceOnStrb_o,
    output logic               voiceOffStrb_o,
    output logic               stealStrb_o,
    output logic [VOICES-1:0]  activeVoices_o,
    output logic               busy_o,
    output logic               overflow_o
);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    state_t state_q, state_d;

    logic [VOICES-1:0]  active_q;
    logic [NOTE_BW-1:0] notes_q [VOICES];
    logic [3:0]         ages_q  [VOICES];

    logic               is_off_q;
    logic [NOTE_BW-1:0] note_q;

    logic [VOICES-1:0]  sel_q;
    logic               on_q, off_q, steal_q, ovf_q;
    logic [NOTE_BW-1:0] vnote_q;

    logic               any_strb, accept, ovf_set;

    logic               hit_found, free_found, old_found;
    logic [VOICES-1:0]  hit_oh, free_oh, old_oh;
    logic [3:0]         old_age;

    assign any_strb = noteOnStrb_i | noteOffStrb_i;
    assign accept   = any_strb && (state_q == IDLE);
    // A strobe while busy is lost; a simultaneous on+off loses the note-on.
    assign ovf_set  = (any_strb && (state_q != IDLE)) ||
                      (noteOnStrb_i && noteOffStrb_i && (state_q == IDLE));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    state_d = ISSUE;
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Voice search: matching note, first free voice, oldest active voice.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        old_found  = 1'b0;
        hit_oh     = '0;
        free_oh    = '0;
        old_oh     = '0;
        old_age    = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (active_q[i] && (notes_q[i] == note_q) && !hit_found) begin
                hit_found = 1'b1;
                hit_oh[i] = 1'b1;
            end
            if (!active_q[i] && !free_found) begin
                free_found = 1'b1;
                free_oh[i] = 1'b1;
            end
            // Strict compare keeps the lowest index on age ties.
            if (active_q[i] && (!old_found || (ages_q[i] > old_age))) begin
                old_found = 1'b1;
                old_age   = ages_q[i];
                old_oh    = '0;
                old_oh[i] = 1'b1;
            end
        end
    end

    // Event latch, output registers, voice table and sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_off_q <= 1'b0;
            note_q   <= '0;
            sel_q    <= '0;
            on_q     <= 1'b0;
            off_q    <= 1'b0;
            steal_q  <= 1'b0;
            vnote_q  <= '0;
            ovf_q    <= 1'b0;
            active_q <= '0;
            for (int i = 0; i < VOICES; i++) begin
                notes_q[i] <= '0;
                ages_q[i]  <= '0;
            end
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_off_q <= noteOffStrb_i;
                        note_q   <= note_i;
                    end
                end
                SCAN: begin
                    if (is_off_q) begin
                        if (hit_found) begin
                            sel_q   <= hit_oh;
                            off_q   <= 1'b1;
                            vnote_q <= note_q;
                        end
                    end else begin
                        on_q    <= 1'b1;
                        vnote_q <= note_q;
                        if (hit_found)       sel_q <= hit_oh;
                        else if (free_found) sel_q <= free_oh;
                        else begin
                            sel_q   <= old_oh;
                            steal_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    sel_q   <= '0;
                    on_q    <= 1'b0;
                    off_q   <= 1'b0;
                    steal_q <= 1'b0;
                    for (int i = 0; i < VOICES; i++) begin
                        if (on_q) begin
                            if (sel_q[i]) begin
                                active_q[i] <= 1'b1;
                                notes_q[i]  <= note_q;
                                ages_q[i]   <= '0;
                            end else if (active_q[i] && (ages_q[i] != 4'd15)) begin
                                ages_q[i] <= ages_q[i] + 4'd1;
                            end
                        end else if (off_q && sel_q[i]) begin
                            active_q[i] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign voiceSel_o     = sel_q;
    assign voiceNote_o    = vnote_q;
    assign voiceOnStrb_o  = on_q;
    assign voiceOffStrb_o = off_q;
    assign stealStrb_o    = steal_q;
    assign activeVoices_o = active_q;
    assign busy_o         = (state_q != IDLE);
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus a randomized
// event stream compared against a voice-table model of the allocation rules.
module tb_voice_alloc;

    localparam int V  = 7;
    localparam int NB = 7;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          noteOnStrb_i = 1'b0;
    logic          noteOffStrb_i = 1'b0;
    logic [NB-1:0] note_i = '0;
    logic [V-1:0]  voiceSel_o;
    logic [NB-1:0] voiceNote_o;
    logic          voiceOnStrb_o, voiceOffStrb_o, stealStrb_o;
    logic [V-1:0]  activeVoices_o;
    logic          busy_o, overflow_o;

    voice_alloc #(.VOICES(V), .NOTE_BW(NB)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .noteOnStrb_i   (noteOnStrb_i),
        .noteOffStrb_i  (noteOffStrb_i),
        .note_i         (note_i),
        .voiceSel_o     (voiceSel_o),
        .voiceNote_o    (voiceNote_o),
        .voiceOnStrb_o  (voiceOnStrb_o),
        .voiceOffStrb_o (voiceOffStrb_o),
        .stealStrb_o    (stealStrb_o),
        .activeVoices_o (activeVoices_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    // Reference voice table.
    bit m_act [V];
    int m_note[V];
    int m_age [V];
    int m_vnote;
    bit m_ovf;

    // Expected results of the latest event.
    bit           exp_on, exp_off, exp_steal;
    logic [V-1:0] exp_sel;
    int           exp_note;

    // Observed values of the latest event.
    bit            obs_busy_scan;
    logic [V+NB+2:0] obs_issue;
    logic [V-1:0]  obs_active;
    logic [V+2:0]  obs_idle_strb;
    bit            obs_ovf;

    function automatic logic [V-1:0] model_active();
        logic [V-1:0] r;
        r = '0;
        for (int i = 0; i < V; i++) r[i] = m_act[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < V; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_age[i] = 0;
        end
        m_vnote = 0;
        m_ovf   = 0;
    endtask

    // Apply one accepted event to the reference table.
    task automatic model_event(input bit on, input bit off, input int n);
        int idx;
        idx = -1;
        exp_on = 0; exp_off = 0; exp_steal = 0; exp_sel = '0;
        if (on && off) m_ovf = 1;
        if (off) begin
            for (int i = 0; i < V; i++)
                if (idx < 0 && m_act[i] && m_note[i] == n) idx = i;
            if (idx >= 0) begin
                exp_off = 1; exp_sel[idx] = 1'b1; m_act[idx] = 0; m_vnote = n;
            end
        end else if (on) begin
            for (int i = 0; i < V; i++)
                if (idx < 0 && m_act[i] && m_note[i] == n) idx = i;
            if (idx < 0)
                for (int i = 0; i < V; i++)
                    if (idx < 0 && !m_act[i]) idx = i;
            if (idx < 0) begin
                exp_steal = 1;
                for (int i = 0; i < V; i++)
                    if (idx < 0 || m_age[i] > m_age[idx]) idx = i;
            end
            for (int i = 0; i < V; i++)
                if (i != idx && m_act[i]) m_age[i] = (m_age[i] >= 15) ? 15 : m_age[i] + 1;
            m_act[idx] = 1; m_note[idx] = n; m_age[idx] = 0;
            exp_on = 1; exp_sel[idx] = 1'b1; m_vnote = n;
        end
        exp_note = m_vnote;
    endtask

    // Drive one event from a negedge with the DUT idle; ends on a negedge, idle again.
    task automatic drive_event(input bit on, input bit off, input int n);
        model_event(on, off, n);
        noteOnStrb_i = on; noteOffStrb_i = off; note_i = NB'(n);
        @(negedge clk_i);
        noteOnStrb_i = 0; noteOffStrb_i = 0;
        obs_busy_scan = busy_o;
        @(negedge clk_i);
        obs_issue = {voiceOnStrb_o, voiceOffStrb_o, stealStrb_o, voiceSel_o, voiceNote_o};
        @(negedge clk_i);
        obs_active    = activeVoices_o;
        obs_idle_strb = {voiceOnStrb_o, voiceOffStrb_o, stealStrb_o, voiceSel_o};
        obs_ovf       = overflow_o;
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        n_total++;
        if ({voiceSel_o, voiceNote_o, voiceOnStrb_o, voiceOffStrb_o, stealStrb_o,
             activeVoices_o, busy_o, overflow_o} !== '0)
            $display("FAIL reset_outputs: got sel=%b note=%0d on=%b off=%b steal=%b act=%b busy=%b ovf=%b, want all 0",
                     voiceSel_o, voiceNote_o, voiceOnStrb_o, voiceOffStrb_o, stealStrb_o,
                     activeVoices_o, busy_o, overflow_o);
        else n_pass++;
        rst_i = 0;
        model_clear();
    endtask

    task automatic test_single_on();
        reset_dut();
        drive_event(1, 0, 60);
        n_total++;
        if (obs_issue !== {1'b1, 1'b0, 1'b0, 7'b0000001, 7'd60})
            $display("FAIL single_on_issue: got %h want %h", obs_issue, {1'b1, 1'b0, 1'b0, 7'b0000001, 7'd60});
        else n_pass++;
        n_total++;
        if (obs_active !== 7'b0000001 || obs_idle_strb !== '0)
            $display("FAIL single_on_after: got act=%b strb=%h want act=0000001 strb=0", obs_active, obs_idle_strb);
        else n_pass++;
        n_total++;
        if (obs_busy_scan !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL single_on_busy: got scan=%b idle=%b want 1/0", obs_busy_scan, busy_o);
        else n_pass++;
    endtask

    task automatic test_release();
        reset_dut();
        drive_event(1, 0, 60);
        drive_event(1, 0, 62);
        drive_event(1, 0, 64);
        drive_event(0, 1, 62);
        n_total++;
        if (obs_issue !== {1'b0, 1'b1, 1'b0, 7'b0000010, 7'd62})
            $display("FAIL release_issue: got %h want %h", obs_issue, {1'b0, 1'b1, 1'b0, 7'b0000010, 7'd62});
        else n_pass++;
        n_total++;
        if (obs_active !== 7'b0000101)
            $display("FAIL release_active: got %b want 0000101", obs_active);
        else n_pass++;
        drive_event(1, 0, 67);
        n_total++;
        if (obs_issue !== {1'b1, 1'b0, 1'b0, 7'b0000010, 7'd67} || obs_active !== 7'b0000111)
            $display("FAIL reuse_freed: got issue=%h act=%b want sel=0000010 act=0000111", obs_issue, obs_active);
        else n_pass++;
    endtask

    task automatic test_steal();
        reset_dut();
        for (int n = 40; n <= 46; n++) drive_event(1, 0, n);
        n_total++;
        if (obs_active !== 7'b1111111)
            $display("FAIL fill_active: got %b want 1111111", obs_active);
        else n_pass++;
        drive_event(1, 0, 50);
        n_total++;
        if (obs_issue !== {1'b1, 1'b0, 1'b1, 7'b0000001, 7'd50} || obs_active !== 7'b1111111)
            $display("FAIL steal_oldest: got issue=%h act=%b want steal sel=0000001 act=1111111", obs_issue, obs_active);
        else n_pass++;
        // Voice 1 is now oldest (age 6); next steal must take it.
        drive_event(1, 0, 51);
        n_total++;
        if (obs_issue !== {1'b1, 1'b0, 1'b1, 7'b0000010, 7'd51})
            $display("FAIL steal_next: got %h want sel=0000010 steal", obs_issue);
        else n_pass++;
    endtask

    task automatic test_retrigger();
        reset_dut();
        drive_event(1, 0, 60);
        drive_event(1, 0, 60);
        n_total++;
        if (obs_issue !== {1'b1, 1'b0, 1'b0, 7'b0000001, 7'd60} || obs_active !== 7'b0000001)
            $display("FAIL retrigger: got issue=%h act=%b want sel=0000001 no steal act=0000001", obs_issue, obs_active);
        else n_pass++;
    endtask

    task automatic test_collision();
        reset_dut();
        drive_event(1, 0, 60);
        drive_event(1, 1, 60);
        n_total++;
        if (obs_issue !== {1'b0, 1'b1, 1'b0, 7'b0000001, 7'd60} || obs_active !== 7'b0 || obs_ovf !== 1'b1)
            $display("FAIL both_strobes: got issue=%h act=%b ovf=%b want off sel=0000001 act=0 ovf=1",
                     obs_issue, obs_active, obs_ovf);
        else n_pass++;
        // Back-to-back: second strobe lands in SCAN and must be dropped.
        reset_dut();
        model_event(1, 0, 60);
        m_ovf = 1;
        noteOnStrb_i = 1; note_i = 7'd60;
        @(negedge clk_i);
        note_i = 7'd61;
        @(negedge clk_i);
        noteOnStrb_i = 0;
        n_total++;
        if ({voiceOnStrb_o, voiceSel_o, voiceNote_o} !== {1'b1, 7'b0000001, 7'd60})
            $display("FAIL back_to_back_first: got on=%b sel=%b note=%0d want 1/0000001/60",
                     voiceOnStrb_o, voiceSel_o, voiceNote_o);
        else n_pass++;
        @(negedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (voiceOnStrb_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b1 ||
            activeVoices_o !== model_active())
            $display("FAIL back_to_back_drop: got on=%b busy=%b ovf=%b act=%b want 0/0/1/%b",
                     voiceOnStrb_o, busy_o, overflow_o, activeVoices_o, model_active());
        else n_pass++;
    endtask

    task automatic test_miss_and_reset();
        reset_dut();
        drive_event(1, 0, 60);
        drive_event(0, 1, 70);
        n_total++;
        if (obs_issue !== {1'b0, 1'b0, 1'b0, 7'b0, 7'd60} || obs_active !== 7'b0000001 || obs_ovf !== 1'b0)
            $display("FAIL off_miss: got issue=%h act=%b ovf=%b want no strobe note=60 act=0000001 ovf=0",
                     obs_issue, obs_active, obs_ovf);
        else n_pass++;
        // Reset pulse while an event sits in SCAN.
        noteOnStrb_i = 1; note_i = 7'd62;
        @(negedge clk_i);
        noteOnStrb_i = 0;
        rst_i = 1;
        #1;
        n_total++;
        if ({voiceSel_o, voiceNote_o, voiceOnStrb_o, voiceOffStrb_o, stealStrb_o,
             activeVoices_o, busy_o, overflow_o} !== '0)
            $display("FAIL reset_in_scan: outputs not all 0 (sel=%b note=%0d act=%b busy=%b)",
                     voiceSel_o, voiceNote_o, activeVoices_o, busy_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_total++;
            if ({voiceOnStrb_o, voiceOffStrb_o, stealStrb_o, voiceSel_o, activeVoices_o, busy_o} !== '0)
                $display("FAIL reset_abort_c%0d: got on=%b off=%b sel=%b act=%b busy=%b want 0",
                         c, voiceOnStrb_o, voiceOffStrb_o, voiceSel_o, activeVoices_o, busy_o);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int r, n;
        bit on, off;
        reset_dut();
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 9));
            n = 60 + int'($urandom_range(0, 9));
            on  = (r <= 5) || (r == 9);
            off = (r >= 6);
            drive_event(on, off, n);
            n_total++;
            if (obs_issue !== {exp_on, exp_off, exp_steal, exp_sel, NB'(exp_note)})
                $display("FAIL random_issue_%0d: got %h want %h", k, obs_issue,
                         {exp_on, exp_off, exp_steal, exp_sel, NB'(exp_note)});
            else n_pass++;
            n_total++;
            if (obs_active !== model_active() || obs_idle_strb !== '0 || obs_ovf !== m_ovf)
                $display("FAIL random_after_%0d: got act=%b strb=%h ovf=%b want act=%b strb=0 ovf=%b",
                         k, obs_active, obs_idle_strb, obs_ovf, model_active(), m_ovf);
            else n_pass++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_on();
        test_release();
        test_steal();
        test_retrigger();
        test_collision();
        test_miss_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
